conv2d_stream: RTL and testbench



---
 rtl/cnn_pkg.sv | 25 ++
 rtl/conv_line_buffer.sv | 58 +++++
 rtl/conv2d_stream.sv | 154 +++++++++++++++
 tb/tb_conv2d_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN convolution path.
package cnn_pkg;

  localparam int CNN_PIX_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} conv_state_t;

  // Accumulator width: full product plus growth for K*K taps plus sign.
  function automatic int acc_width(input int pix_w, input int wt_w, input int k);
    return pix_w + wt_w + $clog2(k * k) + 1;
  endfunction

  // Arithmetic right shift then clamp into a signed out_w-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int shift, input int out_w);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row RAMs plus a KxK window register. window_out is the window as it
// looks once the current pix_in/col is shifted in, so the product stage can
// register directly off the accepting edge.
module conv_line_buffer
#(
  parameter int IMG_W = 28,
  parameter int K     = 3,
  parameter int PIX_W = 8,
  parameter int CW    = 5
) (
  input  logic                             clk,
  input  logic                             shift_en,
  input  logic [CW-1:0]                    col,
  input  logic [PIX_W-1:0]                 pix_in,
  output logic [K-1:0][K-1:0][PIX_W-1:0]   window_out
);

  logic [K-1:0][K-1:0][PIX_W-1:0] win;
  logic [K-1:0][PIX_W-1:0]        col_new;

  generate
    if (K > 1) begin : g_rows
      logic [PIX_W-1:0] ram [K-1][IMG_W];

      // Incoming column: oldest row from the deepest RAM, newest is pix_in.
      always_comb begin
        col_new = '0;
        col_new[K-1] = pix_in;
        for (int r = 0; r < K - 1; r++) col_new[r] = ram[K-2-r][col];
      end

      // Each RAM hands its pixel at this column down to the next-older row.
      always_ff @(posedge clk) begin
        if (shift_en) begin
          ram[0][col] <= pix_in;
          for (int i = 1; i < K - 1; i++) ram[i][col] <= ram[i-1][col];
        end
      end
    end else begin : g_k1
      assign col_new = pix_in;
    end
  endgenerate

  // Next-window view: shift columns left, new column enters on the right.
  always_comb begin
    window_out = win;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) window_out[r][c] = win[r][c+1];
      window_out[r][K-1] = col_new[r];
    end
  end

  // Window register follows the accepted stream.
  always_ff @(posedge clk) begin
    if (shift_en) win <= window_out;
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK valid-padding convolution, N_FILT filters in parallel.
// Optional fused ReLU when CONV_RELU_EN is defined.
module conv2d_stream
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int N_FILT = 4,
  parameter int PIX_W  = CNN_PIX_W,
  parameter int WT_W   = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIX_W-1:0]             in_pix,
  input  logic                         wt_we,
  input  logic [((N_FILT*K*K > 1) ? $clog2(N_FILT*K*K) : 1)-1:0] wt_addr,
  input  logic [WT_W-1:0]              wt_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_FILT*OUT_W-1:0]      out_data,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int NT     = K * K;
  localparam int NW     = N_FILT * NT;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ACC_W  = acc_width(PIX_W, WT_W, K);
  localparam int PROD_W = PIX_W + WT_W + 1;
  localparam int STAGES = 2;

  conv_state_t                          state;
  logic [CW-1:0]                        col;
  logic [RW-1:0]                        row;
  logic [STAGES:1]                      vld_pipe;
  logic [NW-1:0][WT_W-1:0]              wt, wt_next;
  logic [K-1:0][K-1:0][PIX_W-1:0]       win;
  logic [N_FILT-1:0][NT-1:0][PROD_W-1:0] prod_nxt, prod;
  logic [N_FILT-1:0][OUT_W-1:0]         res;
  logic adv, take, last_pix, win_hit, wt_ok;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && (state != S_DRAIN);
  assign take      = in_valid && in_ready;
  assign last_pix  = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
  assign win_hit   = take && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign out_valid = vld_pipe[STAGES];
  assign wt_ok     = wt_we && (state == S_IDLE) && (32'(wt_addr) < NW);

  // Idle-only weight write, forwarded so a same-cycle first pixel sees it.
  always_comb begin
    wt_next = wt;
    if (wt_ok) wt_next[wt_addr] = wt_data;
  end

  // Weight storage.
  always_ff @(posedge clk) begin
    if (reset) wt <= '0;
    else       wt <= wt_next;
  end

  conv_line_buffer #(.IMG_W(IMG_W), .K(K), .PIX_W(PIX_W), .CW(CW)) u_lb (
    .clk        (clk),
    .shift_en   (take),
    .col        (col),
    .pix_in     (in_pix),
    .window_out (win)
  );

  // Per-filter datapath: products, adder tree, shift/saturate, optional ReLU.
  generate
    for (genvar f = 0; f < N_FILT; f++) begin : g_filt
      logic signed [ACC_W-1:0] acc;
      logic signed [OUT_W-1:0] sat;

      for (genvar t = 0; t < NT; t++) begin : g_tap
        logic signed [PROD_W-1:0] px_s, wt_s;
        assign px_s = PROD_W'({1'b0, win[t/K][t%K]});
        assign wt_s = PROD_W'($signed(wt_next[f*NT+t]));
        assign prod_nxt[f][t] = px_s * wt_s;
      end

      // Sum the registered products of this filter.
      always_comb begin
        acc = '0;
        for (int t = 0; t < NT; t++) acc = acc + ACC_W'($signed(prod[f][t]));
      end

      assign sat = OUT_W'(sat_shift(64'(acc), SHIFT, OUT_W));
`ifdef CONV_RELU_EN
      assign res[f] = sat[OUT_W-1] ? '0 : sat;
`else
      assign res[f] = sat;
`endif
    end
  endgenerate

  // Stage 1: product registers, frozen on stall.
  always_ff @(posedge clk) begin
    if (adv) prod <= prod_nxt;
  end

  // Valid shift register and stage 2 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      out_data <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], win_hit};
      if (vld_pipe[STAGES-1]) out_data <= res;
    end
  end

  // Raster counters and frame FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (take) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (take) begin
          state <= last_pix ? S_DRAIN : S_RUN;
          busy  <= 1'b1;
        end
        S_RUN: if (take && last_pix) state <= S_DRAIN;
        S_DRAIN: if (out_valid && out_ready && !vld_pipe[STAGES-1]) begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: 5x5 image, 3x3 kernel, two filters; one DUT with
// SHIFT=0 and one with SHIFT=2 share all inputs.
module tb_conv2d_stream;

  localparam int W = 5, H = 5, KK = 3, NF = 2, NO = (W-KK+1)*(H-KK+1);

  logic clk = 1'b0, reset, in_valid, wt_we, out_ready;
  logic [7:0] in_pix, wt_data;
  logic [4:0] wt_addr;
  logic in_ready_a, out_valid_a, busy_a, frame_done_a;
  logic in_ready_b, out_valid_b, busy_b, frame_done_b;
  logic [31:0] out_data_a, out_data_b;

  always #5 clk = ~clk;

  conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(KK), .N_FILT(NF), .PIX_W(8), .WT_W(8),
                  .OUT_W(16), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_pix(in_pix),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a), .frame_done(frame_done_a));

  conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(KK), .N_FILT(NF), .PIX_W(8), .WT_W(8),
                  .OUT_W(16), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_pix(in_pix),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b), .frame_done(frame_done_b));

  int total = 0, bad = 0;
  int img[W*H];
  int wm[NF*KK*KK];
  logic [31:0] got0[$], got1[$], exp0[$], exp1[$];
  int fd_a = 0, fd_b = 0, fr_base = 0, tgt = 0;
  int lit[NO] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  // Record every handshaked result and every frame_done pulse.
  always @(negedge clk) begin
    if (out_valid_a && out_ready) begin
      got0.push_back(out_data_a);
      got1.push_back(out_data_b);
    end
    if (frame_done_a) fd_a <= fd_a + 1;
    if (frame_done_b) fd_b <= fd_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: shift, saturate to 16 bits, optional ReLU.
  function automatic int satq(input int s, input int sh);
    int v;
    v = s >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic build_exp();
    exp0.delete(); exp1.delete();
    for (int oy = 0; oy <= H-KK; oy++)
      for (int ox = 0; ox <= W-KK; ox++) begin
        logic [31:0] e0, e1;
        for (int f = 0; f < NF; f++) begin
          int s = 0;
          for (int r = 0; r < KK; r++)
            for (int c = 0; c < KK; c++)
              s += img[(oy+r)*W + ox + c] * wm[f*KK*KK + r*KK + c];
          e0[f*16 +: 16] = 16'(satq(s, 0));
          e1[f*16 +: 16] = 16'(satq(s, 2));
        end
        exp0.push_back(e0); exp1.push_back(e1);
      end
  endtask

  task automatic write_wt(input int a, input int v);
    wt_we = 1'b1; wt_addr = 5'(a); wt_data = 8'(v);
    @(posedge clk); #1;
    wt_we = 1'b0;
    wm[a] = v;
  endtask

  task automatic send_pix(input int p);
    int n = 0;
    in_valid = 1'b1; in_pix = 8'(p);
    @(negedge clk);
    while (!in_ready_a && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("in_accept_timeout", 32'(n), 32'(299));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_pix(img[i]);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: hold low through first result + 5 cycles.
  task automatic drive_ready(input int mode);
    int n = 0;
    if (mode == 2) begin
      logic [31:0] d0, d1;
      out_ready = 1'b0;
      do begin @(negedge clk); n++; end while (!out_valid_a && n < 500);
      check("stall_first_valid", 32'(out_valid_a), 32'd1);
      d0 = out_data_a; d1 = out_data_b;
      repeat (5) begin
        @(negedge clk);
        check("stall_valid", 32'(out_valid_a), 32'd1);
        check("stall_in_ready", 32'(in_ready_a), 32'd0);
        check("stall_data_a", out_data_a, d0);
        check("stall_data_b", out_data_b, d1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      n = 0;
    end
    while (got0.size() < tgt && n < 2000) begin
      @(posedge clk); #1;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    out_ready = 1'b1;
  endtask

  task automatic wr_while_busy();
    repeat (6) @(posedge clk);
    #1;
    check("busy_at_write", 32'(busy_a), 32'd1);
    wt_we = 1'b1; wt_addr = 5'd4; wt_data = 8'd5;
    @(posedge clk); #1;
    wt_we = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit gaps, input bit wr_busy);
    int fa, fb, n;
    build_exp();
    fr_base = got0.size(); tgt = fr_base + NO;
    fa = fd_a; fb = fd_b;
    fork
      send_frame(W*H, gaps);
      drive_ready(mode);
      if (wr_busy) wr_while_busy();
    join
    n = 0;
    while (fd_a == fa && n < 50) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("result_count", 32'(got0.size() - fr_base), 32'(NO));
    check("frame_done_a", 32'(fd_a - fa), 32'd1);
    check("frame_done_b", 32'(fd_b - fb), 32'd1);
    check("busy_end", 32'({busy_a, busy_b}), 32'd0);
    for (int i = 0; i < NO; i++)
      if (fr_base + i < got0.size()) begin
        check($sformatf("res_s0_%0d", i), got0[fr_base+i], exp0[i]);
        check($sformatf("res_s2_%0d", i), got1[fr_base+i], exp1[i]);
      end
  endtask

  task automatic load_weights_rand();
    for (int a = 0; a < NF*KK*KK; a++) write_wt(a, int'($urandom_range(0, 255)) - 128);
  endtask

  initial begin
    int fa;
    reset = 1'b1; in_valid = 1'b0; in_pix = '0; wt_we = 1'b0; wt_addr = '0;
    wt_data = '0; out_ready = 1'b1;
    foreach (wm[i]) wm[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
    check("rst_out_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    check("rst_out_data", out_data_a | out_data_b, 32'd0);
    check("rst_busy_done", 32'({busy_a, busy_b, frame_done_a, frame_done_b}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Centre-tap identity on filter 0, box filter on filter 1, ramp image.
    write_wt(4, 1);
    for (int a = 9; a < 18; a++) write_wt(a, 1);
    for (int i = 0; i < W*H; i++) img[i] = i;
    run_frame(0, 0, 0);
    for (int i = 0; i < NO; i++) check("ramp_centre", 32'(got0[fr_base+i][15:0]), 32'(lit[i]));

    // Constant image through the box filter.
    for (int i = 0; i < W*H; i++) img[i] = 10;
    run_frame(1, 1, 0);
    for (int i = 0; i < NO; i++) begin
      check("box_s0", 32'(got0[fr_base+i][31:16]), 32'd90);
      check("box_s2", 32'(got1[fr_base+i][31:16]), 32'd22);
    end

    // Saturation both ways.
    for (int a = 0; a < 18; a++) write_wt(a, 127);
    for (int i = 0; i < W*H; i++) img[i] = 255;
    run_frame(1, 0, 0);
    check("sat_pos", 32'(got0[fr_base][15:0]), 32'h7fff);
    for (int a = 0; a < 18; a++) write_wt(a, -128);
    run_frame(0, 0, 0);
`ifdef CONV_RELU_EN
    check("sat_neg", 32'(got0[fr_base][15:0]), 32'h0000);
`else
    check("sat_neg", 32'(got0[fr_base][15:0]), 32'h8000);
`endif

    // Backpressure on the first result.
    load_weights_rand();
    for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(0, 255));
    run_frame(2, 1, 0);

    // Write while busy is dropped; the same write while idle takes effect.
    for (int a = 0; a < 9; a++) write_wt(a, (a == 4) ? 1 : 0);
    for (int i = 0; i < W*H; i++) img[i] = i;
    run_frame(0, 0, 1);
    write_wt(4, 5);
    run_frame(1, 0, 0);
    for (int i = 0; i < NO; i++) check("x5_centre", 32'(got0[fr_base+i][15:0]), 32'(5*lit[i]));

    // Reset in the middle of a frame.
    for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(0, 255));
    send_frame(12, 0);
    fa = fd_a;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (wm[i]) wm[i] = 0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    repeat (10) @(posedge clk);
    check("midrst_no_done", 32'(fd_a), 32'(fa));
    #1;
    load_weights_rand();
    run_frame(1, 1, 0);

    // Random frames.
    repeat (2) begin
      load_weights_rand();
      for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(0, 255));
      run_frame(1, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
